// File: rtl/path_tracer_pkg.sv
// Constants shared between the shortest-path solver, its table writer and the path tracer.
package path_tracer_pkg;

  localparam int DEFAULT_MAX_NODES   = 16;
  localparam int DEFAULT_INDEX_WIDTH = 8;
  localparam int DEFAULT_MADDR_WIDTH = 16;
  localparam int DEFAULT_MDATA_WIDTH = 32;

  // Predecessor-table marker for a node the solver never reached.
  localparam logic [DEFAULT_INDEX_WIDTH-1:0] NO_PREVIOUS_NODE = '1;

endpackage

// File: rtl/path_stack.sv
// LIFO of node indices; clear and push in the same cycle leaves exactly the pushed entry.
module path_stack #(
  parameter int DEPTH       = 16,
  parameter int WIDTH       = 8,
  parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_dat_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       top_o,
  output logic [COUNT_WIDTH-1:0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [AW-1:0]          wr_idx, top_idx;

  assign full_o  = (count_q == COUNT_WIDTH'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign wr_idx  = clear_i ? '0 : AW'(count_q);
  assign top_idx = AW'(count_q - COUNT_WIDTH'(1));
  assign top_o   = empty_o ? '0 : mem_q[top_idx];

  always_comb begin
    count_d = count_q;
    if (clear_i)                 count_d = push_i ? COUNT_WIDTH'(1) : '0;
    else if (push_i && !full_o)  count_d = count_q + COUNT_WIDTH'(1);
    else if (pop_i && !empty_o)  count_d = count_q - COUNT_WIDTH'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  always_ff @(posedge clock) begin
    if (push_i && (clear_i || !full_o)) mem_q[wr_idx] <= push_dat_i;
  end

endmodule

// File: rtl/path_tracer.sv
// Walks the solver's predecessor table from destination back to source, then streams the
// path source-first; any missing/out-of-range predecessor or cycle ends the trace in ERROR.
module path_tracer
  import path_tracer_pkg::*;
#(
  parameter int MAX_NODES   = DEFAULT_MAX_NODES,
  parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
  parameter int MADDR_WIDTH = DEFAULT_MADDR_WIDTH,
  parameter int MDATA_WIDTH = DEFAULT_MDATA_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic [INDEX_WIDTH-1:0] source_i,
  input  logic [INDEX_WIDTH-1:0] destination_i,
  input  logic [INDEX_WIDTH-1:0] number_of_nodes_i,
  input  logic [MADDR_WIDTH-1:0] prev_base_address_i,
  output logic                   mem_read_enable_o,
  output logic [MADDR_WIDTH-1:0] mem_addr_o,
  input  logic [MDATA_WIDTH-1:0] mem_read_data_i,
  input  logic                   mem_read_ready_i,
  output logic                   path_valid_o,
  output logic [INDEX_WIDTH-1:0] path_node_o,
  output logic                   path_last_o,
  input  logic                   path_ready_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o
);

  localparam int BYTES_PER_ENTRY = MDATA_WIDTH / 8;
  localparam int COUNT_WIDTH     = $clog2(MAX_NODES + 1);

  typedef enum logic [2:0] {IDLE, FETCH, CHECK, DRAIN, DONE, ERROR} state_t;

  state_t                 state_q;
  logic [INDEX_WIDTH-1:0] source_q, nodes_q, cur_q, p_q;
  logic [MADDR_WIDTH-1:0] base_q;
  logic                   busy_q, done_q, error_q;

  logic                   stk_clear, stk_push, stk_pop, stk_full, stk_empty;
  logic [INDEX_WIDTH-1:0] stk_push_dat, stk_top;
  logic [COUNT_WIDTH-1:0] stk_count;
  logic                   start_ok, check_fail;
  logic                   unused_data_bits;

  assign unused_data_bits = ^mem_read_data_i[MDATA_WIDTH-1:INDEX_WIDTH] ^ stk_empty;

  assign start_ok   = start_i && (state_q == IDLE || state_q == DONE || state_q == ERROR);
  // Count reaching the node count means the walk revisited a node.
  assign check_fail = (p_q == INDEX_WIDTH'(NO_PREVIOUS_NODE)) || (p_q >= nodes_q) ||
                      (int'(stk_count) == int'(nodes_q)) || stk_full;

  always_comb begin
    stk_clear    = start_ok;
    stk_push     = 1'b0;
    stk_push_dat = p_q;
    stk_pop      = 1'b0;
    if (start_ok) begin
      stk_push     = 1'b1;
      stk_push_dat = destination_i;
    end else if (state_q == CHECK && !check_fail) begin
      stk_push = 1'b1;
    end else if (state_q == DRAIN && path_ready_i) begin
      stk_pop = 1'b1;
    end
  end

  path_stack #(.DEPTH(MAX_NODES), .WIDTH(INDEX_WIDTH), .COUNT_WIDTH(COUNT_WIDTH)) u_stack (
    .clock      (clock),
    .reset      (reset),
    .clear_i    (stk_clear),
    .push_i     (stk_push),
    .push_dat_i (stk_push_dat),
    .pop_i      (stk_pop),
    .top_o      (stk_top),
    .count_o    (stk_count),
    .full_o     (stk_full),
    .empty_o    (stk_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      source_q <= '0;
      nodes_q  <= '0;
      cur_q    <= '0;
      p_q      <= '0;
      base_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (start_ok) begin
            source_q <= source_i;
            nodes_q  <= number_of_nodes_i;
            base_q   <= prev_base_address_i;
            cur_q    <= destination_i;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            state_q  <= (destination_i == source_i) ? DRAIN : FETCH;
          end
        end
        FETCH: begin
          if (mem_read_ready_i) begin
            p_q     <= mem_read_data_i[INDEX_WIDTH-1:0];
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (check_fail) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            error_q <= 1'b1;
            state_q <= ERROR;
          end else if (p_q == source_q) begin
            state_q <= DRAIN;
          end else begin
            cur_q   <= p_q;
            state_q <= FETCH;
          end
        end
        DRAIN: begin
          if (path_ready_i && stk_count == COUNT_WIDTH'(1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_read_enable_o = (state_q == FETCH);
  assign mem_addr_o        = mem_read_enable_o ?
                             base_q + MADDR_WIDTH'(cur_q) * MADDR_WIDTH'(BYTES_PER_ENTRY) : '0;
  assign path_valid_o      = (state_q == DRAIN);
  assign path_node_o       = path_valid_o ? stk_top : '0;
  assign path_last_o       = path_valid_o && (stk_count == COUNT_WIDTH'(1));
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign error_o           = error_q;

endmodule
